// File: rtl/c7b_ifu_pkg.sv
// Shared IFU types and constants: instruction/PC widths, fetch block width
// and the entry layout held by the instruction buffer.
package c7b_ifu_pkg;

  localparam int INST_W  = 32;
  localparam int PC_W    = 32;
  localparam int FETCH_W = 64;
  localparam logic [PC_W-1:0] RESET_PC = 32'h1c00_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;

  // Words a fetch block contributes: a block entered mid-way (pc[2]=1) only
  // carries the upper instruction.
  function automatic logic [1:0] fetch_nwr(input logic [PC_W-1:0] pc);
    return pc[2] ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/c7bifu_ibuf_if.sv
// Fetch-return / decode bundle of the instruction buffer. The slave side is
// the buffer itself; the master side is the fetch and decode environment.
interface c7bifu_ibuf_if
  import c7b_ifu_pkg::*;
#(
  parameter int DEPTH = 8
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               icu_ifu_data_valid_ic2;
  logic [FETCH_W-1:0] icu_ifu_data_ic2;
  logic [PC_W-1:0]    ifu_pc_ic2;
  logic               ifu_flush;
  logic               exu_ifu_stall;
  logic               ifu_exu_valid_d;
  logic [INST_W-1:0]  ifu_exu_inst_d;
  logic [PC_W-1:0]    ifu_exu_pc_d;
  logic               ibuf_afull;
  logic               ibuf_empty;
  logic [CNT_W-1:0]   ibuf_cnt;

  modport master (
    output icu_ifu_data_valid_ic2, icu_ifu_data_ic2, ifu_pc_ic2, ifu_flush, exu_ifu_stall,
    input  ifu_exu_valid_d, ifu_exu_inst_d, ifu_exu_pc_d, ibuf_afull, ibuf_empty, ibuf_cnt
  );

  modport slave (
    input  icu_ifu_data_valid_ic2, icu_ifu_data_ic2, ifu_pc_ic2, ifu_flush, exu_ifu_stall,
    output ifu_exu_valid_d, ifu_exu_inst_d, ifu_exu_pc_d, ibuf_afull, ibuf_empty, ibuf_cnt
  );

endinterface

// File: rtl/c7bifu_ibuf_chk.sv
// Protocol checker for the instruction buffer: flags a fetch block that does
// not fit and keeps a running count of such events.
module c7bifu_ibuf_chk (
  input  logic       clk,
  input  logic       reset,
  input  logic       ovf,
  output logic [7:0] ovf_events
);

  // Overflow means fcl ignored ibuf_afull; the block has already been dropped.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_events <= 8'd0;
    end else begin
      assert (!ovf) else begin
        ovf_events <= ovf_events + 8'd1;
        $warning("c7bifu_ibuf overflow: fetch block dropped");
      end
    end
  end

endmodule

// File: rtl/c7bifu_ibuf_mem.sv
// Instruction buffer storage: DEPTH entries, two write ports, one async read.
// Contents are deliberately not reset; the control logic masks invalid heads.
module c7bifu_ibuf_mem
  import c7b_ifu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we0,
  input  logic [PTR_W-1:0] waddr0,
  input  ibuf_entry_t wdata0,
  input  logic        we1,
  input  logic [PTR_W-1:0] waddr1,
  input  ibuf_entry_t wdata1,
  input  logic [PTR_W-1:0] raddr,
  output ibuf_entry_t rdata
);

  ibuf_entry_t mem_r [DEPTH];

  // Write ports never collide: waddr1 is always waddr0+1 and DEPTH >= 4.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_r[waddr0] <= wdata0;
    end
    if (we1) begin
      mem_r[waddr1] <= wdata1;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/c7bifu_ibuf.sv
// Instruction buffer between IC2 fetch return and decode: up to two words in,
// one word out per cycle, first-word fall-through, almost-full throttle to fcl.
module c7bifu_ibuf
  import c7b_ifu_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 4
) (
  input logic        clk,
  input logic        reset,
  c7bifu_ibuf_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s, waddr1_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             empty_r, afull_r;
  logic             valid_s, pop_s, push_req_s, ovf_s, push_ok_s, mid_s;
  logic [1:0]       nwr_s;
  logic [CNT_W:0]   room_s;
  logic             we0_s, we1_s;
  ibuf_entry_t      wdata0_s, wdata1_s, head_s;

  // Push/pop decisions, write data steering and next-state pointers/count.
  always_comb begin
    valid_s    = !empty_r;
    pop_s      = valid_s && !bus.exu_ifu_stall;
    push_req_s = bus.icu_ifu_data_valid_ic2 && !bus.ifu_flush;
    mid_s      = bus.ifu_pc_ic2[2];
    nwr_s      = fetch_nwr(bus.ifu_pc_ic2);
    // A pop in the same cycle frees a slot, so a full buffer can still take one word.
    room_s     = (CNT_W+1)'(DEPTH) - {1'b0, cnt_r} + {{CNT_W{1'b0}}, pop_s};
    ovf_s      = push_req_s && ({{(CNT_W-1){1'b0}}, nwr_s} > room_s);
    push_ok_s  = push_req_s && !ovf_s;
    we0_s      = push_ok_s;
    we1_s      = push_ok_s && !mid_s;
    waddr1_s   = wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};

    wdata0_s.pc   = bus.ifu_pc_ic2;
    wdata0_s.inst = mid_s ? bus.icu_ifu_data_ic2[63:32] : bus.icu_ifu_data_ic2[31:0];
    wdata1_s.pc   = bus.ifu_pc_ic2 + 32'd4;
    wdata1_s.inst = bus.icu_ifu_data_ic2[63:32];

    if (bus.ifu_flush) begin
      cnt_nxt_s    = {CNT_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      cnt_nxt_s    = cnt_r + (push_ok_s ? CNT_W'(nwr_s) : {CNT_W{1'b0}}) - CNT_W'(pop_s);
      wr_ptr_nxt_s = wr_ptr_r + (push_ok_s ? PTR_W'(nwr_s) : {PTR_W{1'b0}});
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
    end
  end

  // Pointer, count and flag state; flags are registered from the next count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      cnt_r    <= cnt_nxt_s;
      empty_r  <= (cnt_nxt_s == {CNT_W{1'b0}});
      afull_r  <= (((CNT_W+1)'(DEPTH) - {1'b0, cnt_nxt_s}) < (CNT_W+1)'(AFULL_THRESH));
    end
  end

  c7bifu_ibuf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we0    (we0_s),
    .waddr0 (wr_ptr_r),
    .wdata0 (wdata0_s),
    .we1    (we1_s),
    .waddr1 (waddr1_s),
    .wdata1 (wdata1_s),
    .raddr  (rd_ptr_r),
    .rdata  (head_s)
  );

  c7bifu_ibuf_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .ovf        (ovf_s),
    .ovf_events ()
  );

  assign bus.ifu_exu_valid_d = valid_s;
  assign bus.ifu_exu_inst_d  = valid_s ? head_s.inst : {INST_W{1'b0}};
  assign bus.ifu_exu_pc_d    = valid_s ? head_s.pc : {PC_W{1'b0}};
  assign bus.ibuf_afull      = afull_r;
  assign bus.ibuf_empty      = empty_r;
  assign bus.ibuf_cnt        = cnt_r;

endmodule
